aes_iter_cipher: RTL and testbench

AES_ITER_CIPHER -- requirements
Module: aes_iter_cipher

---
 rtl/aes_iter_cipher.sv | 229 ++++++++++++++++++++++
 tb/tb_aes_iter_cipher.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_cipher.sv
// aes_iter_cipher: iterative AES encryption core, one full round per clock.
//
// A key is loaded with key_load and expanded on-chip at one schedule word per
// cycle into a register file. The schedule is kept until the next key_load,
// so any number of blocks can then be encrypted without re-expanding it.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous active-high reset
//   key_in     cipher key, most significant byte is key byte 0
//   key_load   single-cycle request to load key_in and expand it
//   key_ready  a fully expanded key schedule is held
//   datain     plaintext block, most significant byte is state byte 0
//   in_valid   datain is valid
//   in_ready   the core accepts datain this cycle
//   dataout    ciphertext block
//   out_valid  dataout holds a valid ciphertext
//   out_ready  the sink accepts dataout
//   busy       key expansion or encryption in progress, or result pending
module aes_iter_cipher #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_load,
  output logic                key_ready,
  input  logic [127:0]        datain,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [127:0]        dataout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_cipher: KEY_BITS must be 128, 192 or 256");
  end

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115, 128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84, 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8, 128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973, 128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479, 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a, 128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df, 128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes fused with ShiftRows: byte (row r, column c) is taken from
  // column (c + r) mod 4 of the input, byte index 4*c + r from the MSB.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = sub_byte(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]), mix_column(s[63:32]), mix_column(s[31:0])};
  endfunction

  typedef enum logic [2:0] {ST_NOKEY, ST_KEYEXP, ST_READY, ST_ROUND, ST_DONE} state_e;

  state_e       state_q, state_d;
  logic [5:0]   word_cnt_q, word_cnt_d;   // index of the schedule word being written
  logic [2:0]   kidx_q, kidx_d;           // word_cnt mod NK, avoids a divider
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] aes_q, aes_d;
  logic [127:0] dout_q, dout_d;
  logic [31:0]  sched_q [NW];

  logic         key_we;
  logic         sched_we;
  logic [31:0]  sched_wdata;
  logic [31:0]  temp;
  logic [127:0] round_key;
  logic [127:0] shifted;
  logic [127:0] round_out;
  logic         accept;

  // Next key-schedule word w[i] = w[i-NK] ^ f(w[i-1]).
  always_comb begin
    temp = sched_q[word_cnt_q - 6'd1];
    if (kidx_q == 3'd0) begin
      temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon_q, 24'h0};
    end else if (NK == 8 && kidx_q == 3'd4) begin
      temp = sub_word(temp);
    end
    sched_wdata = sched_q[word_cnt_q - 6'(NK)] ^ temp;
  end

  // One cipher round; the last round skips MixColumns.
  always_comb begin
    round_key = {sched_q[{round_q, 2'd0}], sched_q[{round_q, 2'd1}],
                 sched_q[{round_q, 2'd2}], sched_q[{round_q, 2'd3}]};
    shifted   = sub_shift(aes_q);
    round_out = (round_q == 4'(NR)) ? (shifted ^ round_key)
                                    : (mix_columns(shifted) ^ round_key);
  end

  assign accept = (state_q == ST_READY) && in_valid && !key_load;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; otherwise this block would infer latches.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    kidx_d     = kidx_q;
    rcon_d     = rcon_q;
    round_d    = round_q;
    aes_d      = aes_q;
    dout_d     = dout_q;
    key_we     = 1'b0;
    sched_we   = 1'b0;

    case (state_q)
      ST_KEYEXP: begin
        sched_we   = 1'b1;
        word_cnt_d = word_cnt_q + 6'd1;
        kidx_d     = (kidx_q == 3'(NK - 1)) ? 3'd0 : kidx_q + 3'd1;
        if (kidx_q == 3'd0) rcon_d = xtime(rcon_q);
        if (word_cnt_q == 6'(NW - 1)) state_d = ST_READY;
      end
      ST_READY: begin
        if (accept) begin
          aes_d   = datain ^ {sched_q[0], sched_q[1], sched_q[2], sched_q[3]};
          round_d = 4'd1;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (round_q == 4'(NR)) begin
          dout_d  = round_out;
          state_d = ST_DONE;
        end else begin
          aes_d   = round_out;
          round_d = round_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_READY;
      end
      default: ;
    endcase

    // A key load (re)starts expansion from any state that is not mid-block;
    // it overrides both an expansion step and a coincident accept.
    if (key_load && (state_q == ST_NOKEY || state_q == ST_KEYEXP || state_q == ST_READY)) begin
      key_we     = 1'b1;
      sched_we   = 1'b0;
      word_cnt_d = 6'(NK);
      kidx_d     = 3'd0;
      rcon_d     = 8'h01;
      state_d    = ST_KEYEXP;
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_NOKEY;
      word_cnt_q <= '0;
      kidx_q     <= '0;
      rcon_q     <= '0;
      round_q    <= '0;
      aes_q      <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      kidx_q     <= kidx_d;
      rcon_q     <= rcon_d;
      round_q    <= round_d;
      aes_q      <= aes_d;
      dout_q     <= dout_d;
    end
  end

  // NOTE: the schedule file has no reset; the FSM never reads it before a
  // key_load has rewritten it, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (key_we) begin
      for (int i = 0; i < NK; i++) sched_q[i] <= key_in[KEY_BITS - 1 - 32*i -: 32];
    end else if (sched_we) begin
      sched_q[word_cnt_q] <= sched_wdata;
    end
  end

  assign key_ready = (state_q == ST_READY) || (state_q == ST_ROUND) || (state_q == ST_DONE);
  assign busy      = (state_q == ST_KEYEXP) || (state_q == ST_ROUND) || (state_q == ST_DONE);
  assign in_ready  = (state_q == ST_READY) && !key_load;
  assign out_valid = (state_q == ST_DONE);
  assign dataout   = dout_q;

endmodule

// File: tb/tb_aes_iter_cipher.sv
// tb_aes_iter_cipher: self-checking bench for aes_iter_cipher.
// Three instances (128/192/256-bit keys) share clock and reset. Expected
// ciphertexts come from a byte-matrix AES model whose S-box is derived from
// the GF(2^8) inverse and affine map, plus the FIPS-197 known answers.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_aes_iter_cipher;

  logic         clk;
  logic         rst;
  logic [255:0] key_in_r [3];
  logic [127:0] datain_r [3];
  logic [2:0]   key_load_r;
  logic [2:0]   in_valid_r;
  logic [2:0]   out_ready_r;
  wire  [2:0]   key_ready_w;
  wire  [2:0]   in_ready_w;
  wire  [2:0]   out_valid_w;
  wire  [2:0]   busy_w;
  wire  [127:0] dataout_w [3];

  logic [255:0] ref_key [3];
  logic [7:0]   sbox_tab [256];
  int           n_cmp = 0;
  int           n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_iter_cipher #(.KEY_BITS(128 + 64*g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in_r[g][255 -: 128 + 64*g]),
      .key_load  (key_load_r[g]),
      .key_ready (key_ready_w[g]),
      .datain    (datain_r[g]),
      .in_valid  (in_valid_r[g]),
      .in_ready  (in_ready_w[g]),
      .dataout   (dataout_w[g]),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready_r[g]),
      .busy      (busy_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] ref_sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [255:0] key, input int nk, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] ct;
    int           nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      tmp = w[i - 1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gf_mul(rc, 8'h02);
        tmp = ref_sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        tmp = ref_sub_word(tmp);
      end
      w[i] = w[i - nk] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_tab[s[r][(c + r) % 4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = (rnd == nr) ? t[r][c]
                  : gf_mul(8'h02, t[r][c]) ^ gf_mul(8'h03, t[(r + 1) % 4][c])
                    ^ t[(r + 2) % 4][c] ^ t[(r + 3) % 4][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] ^= w[4*rnd + c][31 - 8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ct[127 - 8*(4*c + r) -: 8] = s[r][c];
    return ct;
  endfunction

  function automatic int nk_of(input int d);   return 4 + 2*d;                endfunction
  function automatic int nr_of(input int d);   return nk_of(d) + 6;           endfunction
  function automatic int kexp_of(input int d); return 4*(nr_of(d) + 1) - nk_of(d); endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] kat_key(input int d);
    case (d)
      0:       return {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
      1:       return {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
      default: return 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    endcase
  endfunction

  function automatic logic [127:0] kat_ct(input int d);
    case (d)
      0:       return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      1:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      default: return 128'h8ea2b7ca516745bfeafc49904b496089;
    endcase
  endfunction

  // ---------------- stimulus tasks (entered just after a falling edge) ----------------
  task automatic load_key(input int d, input logic [255:0] key, input bit with_valid);
    int n;
    key_in_r[d]   = key;
    key_load_r[d] = 1'b1;
    in_valid_r[d] = with_valid;
    datain_r[d]   = rand128();
    @(negedge clk);
    key_load_r[d] = 1'b0;
    in_valid_r[d] = 1'b0;
    key_in_r[d]   = rand256();
    ref_key[d]    = key;
    check("keyexp_entry busy/key_ready/out_valid", {busy_w[d], key_ready_w[d], out_valid_w[d]}, 3'b100);
    n = 0;
    while (!key_ready_w[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("key_expansion_cycles", n, kexp_of(d));
    check("key_done key_ready/busy/out_valid", {key_ready_w[d], busy_w[d], out_valid_w[d]}, 3'b100);
  endtask

  task automatic run_block(input int d, input logic [127:0] pt, input int hold, input bit poke,
                           output logic [127:0] ct);
    int           n;
    int           poke_at;
    bit           ok;
    logic [127:0] held;
    out_ready_r[d] = (hold == 0);
    datain_r[d]    = pt;
    in_valid_r[d]  = 1'b1;
    n = 0;
    while (!in_ready_w[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", in_ready_w[d], 1'b1);
    @(negedge clk);
    in_valid_r[d] = 1'b0;
    ok = 1'b1;
    n = 0;
    poke_at = $urandom_range(nr_of(d) - 1, 0);
    while (!out_valid_w[d] && n < 40) begin
      ok &= !in_ready_w[d] && busy_w[d] && key_ready_w[d];
      in_valid_r[d] = 1'($urandom);
      datain_r[d]   = rand128();
      key_load_r[d] = poke && (n == poke_at);
      key_in_r[d]   = rand256();
      @(negedge clk);
      n++;
    end
    in_valid_r[d] = 1'b0;
    key_load_r[d] = 1'b0;
    check("latency_edges", n, nr_of(d));
    check("round_phase in_ready=0 busy=1 key_ready=1", ok, 1'b1);
    ct = dataout_w[d];
    check("ciphertext_vs_model", ct, aes_ref(ref_key[d], nk_of(d), pt));
    held = dataout_w[d];
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      key_load_r[d] = poke && (i == 0);
      @(negedge clk);
      ok &= out_valid_w[d] && !in_ready_w[d] && (dataout_w[d] == held);
    end
    key_load_r[d] = 1'b0;
    if (hold > 0) check("done_hold_stable", ok, 1'b1);
    out_ready_r[d] = 1'b1;
    @(negedge clk);
    check("release out_valid/in_ready/key_ready", {out_valid_w[d], in_ready_w[d], key_ready_w[d]}, 3'b011);
    out_ready_r[d] = 1'b0;
  endtask

  // in_valid without any key: nothing may ever be accepted.
  task automatic nokey_ignore();
    bit ok [3];
    for (int d = 0; d < 3; d++) ok[d] = 1'b1;
    in_valid_r = 3'b111;
    for (int i = 0; i < 25; i++) begin
      for (int d = 0; d < 3; d++) begin
        datain_r[d]    = rand128();
        out_ready_r[d] = 1'($urandom);
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        ok[d] &= !in_ready_w[d] && !out_valid_w[d] && !busy_w[d] && !key_ready_w[d];
    end
    in_valid_r  = 3'b000;
    out_ready_r = 3'b000;
    for (int d = 0; d < 3; d++) check("nokey_ignores_in_valid", ok[d], 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] ct;
    int           hold;
    rst         = 1'b1;
    key_load_r  = '0;
    in_valid_r  = '0;
    out_ready_r = '0;
    for (int d = 0; d < 3; d++) begin
      key_in_r[d] = '0;
      datain_r[d] = '0;
      ref_key[d]  = '0;
    end
    build_sbox();

    #3;
    for (int d = 0; d < 3; d++) begin
      check("reset flags", {key_ready_w[d], in_ready_w[d], out_valid_w[d], busy_w[d]}, 4'b0000);
      check("reset dataout", dataout_w[d], 128'h0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    nokey_ignore();

    // Known answers, then a 20-cycle back-pressure hold.
    for (int d = 0; d < 3; d++) begin
      load_key(d, kat_key(d), 1'b0);
      run_block(d, 128'h00112233445566778899aabbccddeeff, 0, 1'b0, ct);
      check("fips197_known_answer", ct, kat_ct(d));
      run_block(d, rand128(), 20, 1'b0, ct);
    end

    // Random keys and blocks, random back-pressure and ignored key_load pulses.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 2; k++) begin
        load_key(d, rand256(), 1'b0);
        for (int b = 0; b < 4; b++) begin
          hold = ($urandom_range(2, 0) == 0) ? 0 : int'($urandom_range(6, 1));
          run_block(d, rand128(), hold, 1'($urandom), ct);
        end
      end
    end

    // key_load during expansion restarts it; key_load in READY wins over in_valid.
    for (int d = 0; d < 3; d++) begin
      key_in_r[d]   = rand256();
      key_load_r[d] = 1'b1;
      @(negedge clk);
      key_load_r[d] = 1'b0;
      repeat (10) @(negedge clk);
      check("restart_key_ready_low", key_ready_w[d], 1'b0);
      load_key(d, rand256(), 1'b0);
      run_block(d, rand128(), 0, 1'b0, ct);
      load_key(d, rand256(), 1'b1);
      run_block(d, rand128(), 1, 1'b0, ct);
    end

    // Asynchronous reset in round 5 of a 256-bit encryption.
    datain_r[2]   = rand128();
    in_valid_r[2] = 1'b1;
    @(negedge clk);
    in_valid_r[2] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midround_reset flags", {key_ready_w[2], in_ready_w[2], out_valid_w[2], busy_w[2]}, 4'b0000);
    check("midround_reset dataout", dataout_w[2], 128'h0);
    @(negedge clk);
    rst = 1'b0;
    nokey_ignore();
    for (int d = 0; d < 3; d++) begin
      load_key(d, rand256(), 1'b0);
      run_block(d, rand128(), 0, 1'b0, ct);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
